// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller for a dual-port RAM (A = write, B = read); rd_valid one cycle after rd_en.
// Backpressure: writes are refused when full and reads when empty; `FIFO_ERR_FLAGS_EN adds sticky overflow/underflow.
module fifo_ctrl #(
  parameter int DATA     = 16,
  parameter int ADDR     = 5,
  parameter int AF_LEVEL = 28,
  parameter int AE_LEVEL = 4
) (
  input  logic            clK,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [DATA-1:0] wr_data,
  output logic            full,
  output logic            almost_full,
  input  logic            rd_en,
  output logic [DATA-1:0] rd_data,
  output logic            rd_valid,
  output logic            empty,
  output logic            almost_empty,
  output logic [ADDR:0]   count,
  output logic            a_port_WR,
  output logic [ADDR-1:0] a_port_ADDR,
  output logic [DATA-1:0] a_port_data_IN,
  output logic            b_port_WR,
  output logic [ADDR-1:0] b_port_ADDR,
  output logic [DATA-1:0] b_port_data_IN,
  input  logic [DATA-1:0] b_port_data_OUT
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic            overflow,
  output logic            underflow
`endif
);

  localparam logic [ADDR:0] PTR_ONE = (ADDR+1)'(1);
  localparam logic [ADDR:0] AF_LVL  = (ADDR+1)'(AF_LEVEL);
  localparam logic [ADDR:0] AE_LVL  = (ADDR+1)'(AE_LEVEL);

  // Extra MSB on each pointer is the wrap bit that separates full from empty.
  logic [ADDR:0] wr_ptr;
  logic [ADDR:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[ADDR-1:0] == rd_ptr[ADDR-1:0]) && (wr_ptr[ADDR] != rd_ptr[ADDR]);
  assign count        = wr_ptr - rd_ptr;
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);

  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  assign a_port_WR      = wr_ok;
  assign a_port_ADDR    = wr_ptr[ADDR-1:0];
  assign a_port_data_IN = wr_data;
  assign b_port_WR      = 1'b0;
  assign b_port_ADDR    = rd_ptr[ADDR-1:0];
  assign b_port_data_IN = '0;

  // The RAM registers its output on the read edge, so data lines up with rd_valid.
  assign rd_data = b_port_data_OUT;

  always_ff @(posedge clK) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      rd_valid <= rd_ok;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clK) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a behavioural dual-port RAM; vector table plus wrap/full/empty/reset sequences.
module tb_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        full, almost_full, rd_valid, empty, almost_empty;
  logic        rd_en;
  logic [15:0] rd_data;
  logic [5:0]  count;
  logic        a_port_WR, b_port_WR;
  logic [4:0]  a_port_ADDR, b_port_ADDR;
  logic [15:0] a_port_data_IN, b_port_data_IN, b_port_data_OUT;
`ifdef FIFO_ERR_FLAGS_EN
  logic        overflow, underflow;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fifo_ctrl dut (
    .clK(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .almost_full(almost_full), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .empty(empty), .almost_empty(almost_empty), .count(count),
    .a_port_WR(a_port_WR), .a_port_ADDR(a_port_ADDR), .a_port_data_IN(a_port_data_IN),
    .b_port_WR(b_port_WR), .b_port_ADDR(b_port_ADDR), .b_port_data_IN(b_port_data_IN),
    .b_port_data_OUT(b_port_data_OUT)
`ifdef FIFO_ERR_FLAGS_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  // Behavioural dpram: synchronous write on A, registered read on B.
  logic [15:0] mem [32];
  always @(posedge clk) begin
    if (a_port_WR) mem[a_port_ADDR] <= a_port_data_IN;
    b_port_data_OUT <= mem[b_port_ADDR];
  end

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] din;
    logic [5:0]  cnt;
    logic        full;
    logic        empty;
    logic        af;
    logic        ae;
    logic        rv;
    logic [15:0] dout;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic wr, input logic rd, input logic [15:0] din);
    wr_en = wr; rd_en = rd; wr_data = din;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic chk_flags(input string tag, input logic [5:0] c);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".full"}, 32'(full), 32'(c == 6'd32));
    chk({tag, ".empty"}, 32'(empty), 32'(c == 6'd0));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(c >= 6'd28));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(c <= 6'd4));
  endtask

  task automatic rd_one(input string tag, input logic [15:0] exp);
    step(1'b0, 1'b1, 16'h0);
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, ".rd_data"}, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    logic [15:0] wexp;
    logic [15:0] rexp;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.rd_valid", 32'(rd_valid), 32'd0);
    chk("reset.a_port_WR", 32'(a_port_WR), 32'd0);
    chk_flags("reset", 6'd0);
    rst = 1'b0;

    // wr rd din cnt full empty af ae rv dout
    vt[0]  = '{1'b1, 1'b0, 16'h1111, 6'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0};
    vt[1]  = '{1'b1, 1'b0, 16'h2222, 6'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0};
    vt[2]  = '{1'b1, 1'b0, 16'h3333, 6'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0};
    vt[3]  = '{1'b0, 1'b1, 16'h0000, 6'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1111};
    vt[4]  = '{1'b1, 1'b1, 16'h4444, 6'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h2222};
    vt[5]  = '{1'b0, 1'b1, 16'h0000, 6'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h3333};
    vt[6]  = '{1'b0, 1'b1, 16'h0000, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h4444};
    vt[7]  = '{1'b0, 1'b1, 16'h0000, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0};
    vt[8]  = '{1'b1, 1'b1, 16'h5555, 6'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0};
    vt[9]  = '{1'b0, 1'b0, 16'h0000, 6'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0};
    vt[10] = '{1'b0, 1'b1, 16'h0000, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h5555};
    vt[11] = '{1'b0, 1'b0, 16'h0000, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0};

    for (int i = 0; i < 12; i++) begin
      step(vt[i].wr, vt[i].rd, vt[i].din);
      chk($sformatf("vec%0d.count", i), 32'(count), 32'(vt[i].cnt));
      chk($sformatf("vec%0d.full", i), 32'(full), 32'(vt[i].full));
      chk($sformatf("vec%0d.empty", i), 32'(empty), 32'(vt[i].empty));
      chk($sformatf("vec%0d.af", i), 32'(almost_full), 32'(vt[i].af));
      chk($sformatf("vec%0d.ae", i), 32'(almost_empty), 32'(vt[i].ae));
      chk($sformatf("vec%0d.rd_valid", i), 32'(rd_valid), 32'(vt[i].rv));
      if (vt[i].rv) chk($sformatf("vec%0d.rd_data", i), 32'(rd_data), 32'(vt[i].dout));
    end
`ifdef FIFO_ERR_FLAGS_EN
    chk("underflow_after_empty_read", 32'(underflow), 32'd1);
    chk("overflow_still_clear", 32'(overflow), 32'd0);
`endif

    // Fill 0x0001..0x0020 from a fresh reset.
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    chk_flags("rst2", 6'd0);
    wr_en = 1'b1; wr_data = 16'h0001; #1;
    chk("a_port_WR.accepted", 32'(a_port_WR), 32'd1);
    for (int k = 1; k <= 32; k++) begin
      step(1'b1, 1'b0, 16'(k));
      chk_flags($sformatf("fill%0d", k), 6'(k));
    end

    // Full with both requests: the read wins, the write is dropped.
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'hDEAD; #1;
    chk("full_both.a_port_WR", 32'(a_port_WR), 32'd0);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    chk_flags("full_both", 6'd31);
    chk("full_both.rd_valid", 32'(rd_valid), 32'd1);
    chk("full_both.rd_data", 32'(rd_data), 32'h0001);
`ifdef FIFO_ERR_FLAGS_EN
    chk("overflow_set", 32'(overflow), 32'd1);
    step(1'b0, 1'b0, 16'h0);
    chk("overflow_held", 32'(overflow), 32'd1);
`endif

    for (int k = 2; k <= 32; k++) rd_one($sformatf("drain%0d", k), 16'(k));
    chk_flags("drained", 6'd0);
    step(1'b0, 1'b0, 16'h0);
    chk("drained.rd_valid", 32'(rd_valid), 32'd0);

    // Fill 20 / read 20 three times; pointers cross the wrap point.
    wexp = 16'h0100; rexp = 16'h0100;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 20; k++) begin
        step(1'b1, 1'b0, wexp);
        wexp++;
      end
      chk_flags($sformatf("wrap%0d.filled", r), 6'd20);
      for (int k = 0; k < 20; k++) begin
        rd_one($sformatf("wrap%0d.rd%0d", r, k), rexp);
        rexp++;
      end
      chk_flags($sformatf("wrap%0d.drained", r), 6'd0);
    end

    // Reset in the middle of a write burst.
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 16'(16'h0A00 + k));
    chk_flags("pre_rst", 6'd10);
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk_flags("mid_rst", 6'd0);
    chk("mid_rst.rd_valid", 32'(rd_valid), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("mid_rst.overflow", 32'(overflow), 32'd0);
    chk("mid_rst.underflow", 32'(underflow), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
